// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
//   Two-entry, first-in-first-out register buffer. The head register drives
//   the stream data directly, so the output is always a registered value.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset, empties the buffer
//   push_i       write push_data_i at the tail this cycle
//   push_data_i  word to write
//   pop_i        drop the head word this cycle (only legal when valid_o)
//   head_o       oldest buffered word
//   valid_o      at least one word is buffered
//   held_o       occupancy, 0..2
// ---------------------------------------------------------------------------
module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       held_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       held_q, held_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        held_d = held_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (held_q == 2'd0) head_d = push_data_i;
                else                tail_d = push_data_i;
                held_d = held_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                held_d = held_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever
                // remains after the head leaves.
                if (held_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            held_q <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            held_q <= held_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (held_q != 2'd0);
    assign held_o  = held_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a synchronous FIFO (registered read data, one cycle latency) and
//   presents the words as a valid/ready stream with a per-frame last marker.
//   A 2-entry output buffer plus one in-flight read slot covers the read
//   latency, so the stream runs at one word per cycle when unstalled.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   fifo_data   FIFO data_out, valid the cycle after a read strobe
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (combinational)
//   m_data      stream data (buffer head)
//   m_valid     stream word available
//   m_ready     downstream accepts this cycle
//   m_last      head word is the last beat of its frame
//   frame_cnt   completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [7:0]       frame_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    logic       inflight_q;
    logic [7:0] beat_q, beat_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] held;
    logic       pop, push;
    logic [2:0] occ;

    assign pop  = m_valid & m_ready;
    // A read whose return cycle shows empty is treated as failed and dropped.
    assign push = inflight_q & ~fifo_empty;

    // Credit check: buffered + in-flight words, counting a same-cycle pop as
    // already gone. Keeping this below 2 means the buffer can never overflow;
    // the pop term is what allows back-to-back reads at full rate.
    assign occ        = {1'b0, held} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = ~rst & ~fifo_empty & (occ < 3'd2);

    stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (fifo_data),
        .pop_i       (pop),
        .head_o      (m_data),
        .valid_o     (m_valid),
        .held_o      (held)
    );

    // Gated by m_valid so the flag is low when nothing is presented
    // (including after reset with FRAME_LEN=1).
    assign m_last = m_valid & (beat_q == LAST_BEAT);

    always_comb begin
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;
        if (pop) begin
            if (m_last) begin
                beat_d      = 8'd0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            beat_q      <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            inflight_q  <= fifo_rd_en;
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [7:0] frame_cnt;

    // second instance, FRAME_LEN=1, fed by a never-empty source
    logic       rst1;
    logic [7:0] fifo_data1 = 8'h00;
    logic       fifo_rd_en1;
    logic [7:0] m_data1;
    logic       m_valid1;
    logic       m_last1;
    logic [7:0] frame_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .frame_cnt(frame_cnt)
    );

    fifo_stream_reader #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst1), .fifo_data(fifo_data1), .fifo_empty(1'b0),
        .fifo_rd_en(fifo_rd_en1), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(1'b1), .m_last(m_last1), .frame_cnt(frame_cnt1)
    );

    // FIFO model: registered read data. The empty flag stays low during the
    // return cycle of a read (as the real FIFO's flag lags), so a read issued
    // then finds nothing and comes back with empty high; force_empty injects
    // that case on demand.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       ret_q = 1'b0;
    logic       force_empty = 1'b0;
    logic       empty_raw;

    assign empty_raw  = (rd_ptr == wr_ptr);
    assign fifo_empty = force_empty | (empty_raw & ~ret_q);

    always @(posedge clk) begin
        ret_q <= fifo_rd_en & ~empty_raw;
        if (fifo_rd_en && !empty_raw) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_rd_en1) fifo_data1 <= fifo_data1 + 8'd1;
    end

    // accepted beats {last,data} and read strobes
    logic [8:0] rx_q [$];
    int         rd_cnt = 0;
    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) rx_q.push_back({m_last, m_data});
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) mem[wr_ptr + i] = first + 8'(i);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic chk_rx(input string tag, input int base, input logic [7:0] first,
                          input int n, input int last_idx);
        chk({tag, "_count"}, rx_q.size() - base, n);
        for (int i = 0; i < n && base + i < rx_q.size(); i++) begin
            chk({tag, "_data"}, rx_q[base + i][7:0], first + 8'(i));
            chk({tag, "_last"}, rx_q[base + i][8], (i == last_idx) ? 1 : 0);
        end
    endtask

    int base;
    int rdb;
    int k;

    initial begin
        rst = 1'b1; rst1 = 1'b1; m_ready = 1'b0;
        load(8'h01, 8);

        // reset with data present
        repeat (2) @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // streaming 0x01..0x08
        rst = 1'b0; m_ready = 1'b1;
        #1 chk("first_rd_en", fifo_rd_en, 1);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("stream_valid", m_valid, 1);
            chk("stream_data", m_data, i);
            chk("stream_last", m_last, (i % 4 == 0) ? 1 : 0);
        end
        @(negedge clk);
        chk("stream_idle_valid", m_valid, 0);
        chk("stream_frame_cnt", frame_cnt, 2);

        // backpressure: 5 words, ready low
        m_ready = 1'b0; rdb = rd_cnt;
        load(8'h01, 5);
        repeat (6) @(negedge clk);
        chk("bp_strobes", rd_cnt - rdb, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'h01);
        base = rx_q.size();
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk_rx("bp_rx", base, 8'h01, 5, 3);
        chk("bp_frame_cnt", frame_cnt, 3);

        // stale empty: the single read's return cycle shows empty
        base = rx_q.size();
        load(8'h21, 1);
        @(negedge clk);
        force_empty = 1'b1;
        @(negedge clk);
        force_empty = 1'b0;
        chk("stale_valid", m_valid, 0);
        repeat (2) @(negedge clk);
        chk("stale_valid2", m_valid, 0);
        chk("stale_rx", rx_q.size() - base, 0);
        chk("stale_frame_cnt", frame_cnt, 3);
        load(8'h22, 3);
        repeat (8) @(negedge clk);
        chk_rx("stale_rx2", base, 8'h22, 3, 2);
        chk("stale_frame_cnt2", frame_cnt, 4);

        // reset mid-frame with two words buffered
        base = rx_q.size();
        load(8'h31, 8);
        repeat (4) @(negedge clk);
        chk("mid_beats", rx_q.size() - base, 2);
        m_ready = 1'b0;
        @(negedge clk);
        chk("mid_valid", m_valid, 1);
        chk("mid_head", m_data, 8'h33);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0; m_ready = 1'b1;
        base = rx_q.size();
        repeat (10) @(negedge clk);
        chk_rx("mid_rx", base, 8'h35, 4, 3);
        chk("mid_frame_cnt", frame_cnt, 1);

        // wrap with FRAME_LEN=1
        rst1 = 1'b0;
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 10) chk("wrap_last", m_last1, 1);
            if (frame_cnt1 == 8'd255) begin
                k = i;
                break;
            end
        end
        chk("wrap_edges_to_255", k, 257);
        chk("wrap_valid", m_valid1, 1);
        @(negedge clk);
        chk("wrap_zero", frame_cnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
